// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter in front of a word-wide data memory.
//   Each requester issues byte, half or word loads and stores. Loads return
//   extended data; sub-word stores become a read-merge-write of the full word.
//   Ports:
//     clk, reset             : single clock, synchronous active-high reset
//     reqN_valid/ready       : request handshake (N = 0, 1), ready only in IDLE
//     reqN_we/size/unsigned  : store flag, access size, load zero-extension
//     reqN_addr/wdata        : byte address, right-aligned store data
//     reqN_rvalid/rdata/err  : one-cycle completion pulse, load data, misaligned flag
//     mem_we/a/wd            : word write enable, word address, word write data
//     mem_rd                 : combinational read data for mem_a
module dmem_arbiter #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [1:0]        req0_size,
    input  logic              req0_unsigned,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [XLEN-1:0]   req0_wdata,
    output logic              req0_rvalid,
    output logic [XLEN-1:0]   req0_rdata,
    output logic              req0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [1:0]        req1_size,
    input  logic              req1_unsigned,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [XLEN-1:0]   req1_wdata,
    output logic              req1_rvalid,
    output logic [XLEN-1:0]   req1_rdata,
    output logic              req1_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [XLEN-1:0]   mem_wd,
    input  logic [XLEN-1:0]   mem_rd
);
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE} state_t;

    state_t            state, state_nx;
    logic              last, owner, gnt, take, done;
    logic              we_q, uns_q, err_q;
    logic [1:0]        size_q, rvalid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q, merged_q, rdata_q;
    logic              misaligned, word_store, sub_store;
    logic [4:0]        sh;
    logic [XLEN-1:0]   mask, lane_rd, load_val, merged;

    // On a tie the requester not granted last wins; a lone requester wins outright.
    assign gnt  = (req0_valid & req1_valid) ? ~last : ~req0_valid;
    assign take = (state == IDLE) & ~reset & (req0_valid | req1_valid);

    assign req0_ready = take & ~gnt;
    assign req1_ready = take & gnt;

    assign misaligned = (size_q == 2'b11) | ((size_q == 2'b01) & addr_q[0]) |
                        ((size_q == 2'b10) & (addr_q[1:0] != 2'b00));
    assign word_store = we_q & ~misaligned & (size_q == 2'b10);
    assign sub_store  = we_q & ~misaligned & (size_q != 2'b10);

    // Little-endian lane position: byte lane addr[1:0], half lane addr[1].
    assign sh      = (size_q == 2'b00) ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
    assign mask    = (size_q == 2'b00) ? XLEN'('hFF) : XLEN'('hFFFF);
    assign lane_rd = mem_rd >> sh;
    assign merged  = (mem_rd & ~(mask << sh)) | ((wdata_q & mask) << sh);

    assign load_val = (size_q == 2'b00) ? {{(XLEN-8){~uns_q & lane_rd[7]}}, lane_rd[7:0]} :
                      (size_q == 2'b01) ? {{(XLEN-16){~uns_q & lane_rd[15]}}, lane_rd[15:0]} :
                      mem_rd;

    assign mem_a  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wd = (state == WRITE) ? merged_q : wdata_q;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Reset overrides everything so an in-flight transaction neither writes nor completes.
    always_comb begin
        state_nx = state;
        mem_we   = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:    state_nx = take ? ACCESS : IDLE;
            ACCESS: begin
                state_nx = sub_store ? WRITE : IDLE;
                done     = ~sub_store;
                mem_we   = word_store;
            end
            WRITE: begin
                state_nx = IDLE;
                done     = 1'b1;
                mem_we   = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        if (reset) begin
            state_nx = IDLE;
            mem_we   = 1'b0;
            done     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last     <= 1'b1;
            owner    <= 1'b0;
            rvalid_q <= 2'b00;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= done ? (owner ? 2'b10 : 2'b01) : 2'b00;
            if (take) begin
                last    <= gnt;
                owner   <= gnt;
                we_q    <= gnt ? req1_we : req0_we;
                size_q  <= gnt ? req1_size : req0_size;
                uns_q   <= gnt ? req1_unsigned : req0_unsigned;
                addr_q  <= gnt ? req1_addr : req0_addr;
                wdata_q <= gnt ? req1_wdata : req0_wdata;
            end
            if (state == ACCESS) begin
                merged_q <= merged;
                rdata_q  <= (misaligned | we_q) ? '0 : load_val;
                err_q    <= misaligned;
            end
        end
    end

    assign req0_rvalid = rvalid_q[0];
    assign req1_rvalid = rvalid_q[1];
    assign req0_rdata  = rvalid_q[0] ? rdata_q : '0;
    assign req1_rdata  = rvalid_q[1] ? rdata_q : '0;
    assign req0_err    = rvalid_q[0] & err_q;
    assign req1_err    = rvalid_q[1] & err_q;
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width; fixed at 32 for this revision.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have, for each requester N in {0,1}, port reqN_valid  input  1  request present.
REQ-006 SHALL have port reqN_ready  output  1  request accepted this cycle (valid & ready).
REQ-007 SHALL have port reqN_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port reqN_size  input  2  00 byte, 01 half, 10 word, 11 treated as misaligned.
REQ-009 SHALL have port reqN_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port reqN_addr  input  ADDR_W  byte address.
REQ-011 SHALL have port reqN_wdata  input  XLEN  store data, right-aligned (bits [7:0] for byte, [15:0] for half).
REQ-012 SHALL have port reqN_rvalid  output  1  one-cycle completion pulse for loads and stores.
REQ-013 SHALL have port reqN_rdata  output  XLEN  extended load data, valid while rvalid.
REQ-014 SHALL have port reqN_err  output  1  misaligned access, valid while rvalid.
REQ-015 SHALL have port mem_we  output  1  word write enable to the data memory.
REQ-016 SHALL have port mem_a  output  ADDR_W  word address, bits [1:0] forced to 00.
REQ-017 SHALL have port mem_wd  output  XLEN  word write data.
REQ-018 SHALL have port mem_rd  input  XLEN  combinational word read data for mem_a.

Function
REQ-019 SHALL implement states IDLE, ACCESS, WRITE; reqN_ready SHALL be asserted only in IDLE, to at most one requester.
REQ-020 In IDLE, one valid requester SHALL be granted immediately; with both valid, the requester not granted last SHALL win (round-robin); the last-grant register resets to 1 so requester 0 wins the first tie.
REQ-021 On acceptance SHALL latch we/size/unsigned/addr/wdata and the owner ID, then go to ACCESS.
REQ-022 Misalignment: half with addr[0]=1, word with addr[1:0]!=00, or size=11; in ACCESS SHALL issue no write, complete with err=1, rdata=0, and return to IDLE.
REQ-023 Load in ACCESS: mem_a = latched word address; SHALL select byte lane addr[1:0] or half lane addr[1] (little-endian), extend per unsigned, register into rdata, return to IDLE.
REQ-024 Word store in ACCESS: mem_we=1, mem_wd=wdata, return to IDLE.
REQ-025 Sub-word store in ACCESS: mem_we=0; SHALL capture mem_rd merged with the new byte/half in the addressed lane, go to WRITE.
REQ-026 WRITE: mem_a held, mem_we=1, mem_wd=merged word, return to IDLE.
REQ-027 The owner's rvalid SHALL pulse exactly one cycle, in the cycle after the final ACCESS/WRITE cycle; the other requester's rvalid SHALL stay 0.
REQ-028 Latency accept->rvalid: load, word store and misaligned = 2 cycles; sub-word store = 3 cycles; throughput one request per transaction (no overlap).
REQ-029 A new request MAY be accepted in the same IDLE cycle in which the previous rvalid pulses.
REQ-030 mem_we SHALL be 0 in IDLE and in every cycle where reset=1.

Reset
REQ-031 On reset SHALL enter IDLE, last-grant = 1, all rvalid/err = 0, rdata = 0, mem_we = 0.
REQ-032 Reset during ACCESS or WRITE SHALL abort the transaction with no memory write and no rvalid pulse.

Verification
REQ-033 Mem word 0x100 = 0x8899AABB; req0 load byte addr 0x103 signed -> rvalid 2 cycles later, rdata=0xFFFFFF88, err=0.
REQ-034 Same word; req1 store half 0x1234 at 0x102 -> exactly one mem_we pulse at cycle 2, mem_wd=0x1234AABB; rvalid1 at cycle 3.
REQ-035 Both valid from reset in the same cycle, back-to-back loads -> grant order 0,1,0,1; each rvalid only to its owner.
REQ-036 req0 load word at 0x101 -> no mem_we, rvalid0 with err=1, rdata=0.
REQ-037 Assert reset during WRITE of a byte store -> mem_we stays 0, no rvalid, memory word unchanged, IDLE next cycle.
